// File: rtl/io_pwr_pkg.sv
// io_pwr_pkg: state encodings and default timing shared by the pad-ring power sequencer and chip top.
package io_pwr_pkg;
    localparam int PWR_STATE_W = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYC = 64;
    localparam int DEF_BIAS_CYC = 16;
    localparam int DEF_OE_CYC = 4;
    localparam int DEF_CNT_W = 8;
    typedef enum logic [PWR_STATE_W-1:0] {
        PWR_OFF      = 3'd0,
        PWR_DEBOUNCE = 3'd1,
        PWR_BIAS     = 3'd2,
        PWR_INEN     = 3'd3,
        PWR_READY    = 3'd4,
        PWR_SHUTDN   = 3'd5,
        PWR_FAULT    = 3'd6
    } pwr_state_e;
endpackage

// File: rtl/io_sync_bit.sv
// io_sync_bit: multi-flop synchronizer for one asynchronous level, cleared to 0 by reset.
module io_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk) begin
        if (rst) chain <= '0;
        else chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/io_ring_pwr_seq.sv
// io_ring_pwr_seq: power-up/down sequencer for one pad-ring segment with supply-loss gating and sticky fault.
module io_ring_pwr_seq
    import io_pwr_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BIAS_CYC = DEF_BIAS_CYC,
    parameter int OE_CYC = DEF_OE_CYC,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vddq_ok_async,
    input  logic                   vdd_ok_async,
    input  logic                   shutdown_req,
    input  logic                   fault_clr,
    output logic                   pad_bias_en,
    output logic                   pad_ie_en,
    output logic                   pad_oe_en,
    output logic                   io_ready,
    output logic                   fault,
    output logic [PWR_STATE_W-1:0] state_o
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(BIAS_CYC - 1);
    localparam logic [CNT_W-1:0] OE_LAST = CNT_W'(OE_CYC - 1);

    logic vddq_s, vdd_s, sup_ok;
    pwr_state_e state, nxt;
    logic [CNT_W-1:0] timer;

    io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vddq (.clk(clk), .rst(rst), .d(vddq_ok_async), .q(vddq_s));
    io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_vdd  (.clk(clk), .rst(rst), .d(vdd_ok_async),  .q(vdd_s));

    assign sup_ok = vddq_s & vdd_s;

    // supply loss outranks shutdown in READY so a dying rail always latches a fault
    always_comb begin
        nxt = PWR_OFF;
        case (state)
            PWR_OFF:      nxt = (sup_ok && !shutdown_req) ? PWR_DEBOUNCE : PWR_OFF;
            PWR_DEBOUNCE: nxt = (!sup_ok || shutdown_req) ? PWR_OFF : (timer == DEB_LAST) ? PWR_BIAS : PWR_DEBOUNCE;
            PWR_BIAS:     nxt = (!sup_ok || shutdown_req) ? PWR_OFF : (timer == BIAS_LAST) ? PWR_INEN : PWR_BIAS;
            PWR_INEN:     nxt = (!sup_ok || shutdown_req) ? PWR_OFF : (timer == OE_LAST) ? PWR_READY : PWR_INEN;
            PWR_READY:    nxt = !sup_ok ? PWR_FAULT : shutdown_req ? PWR_SHUTDN : PWR_READY;
            PWR_SHUTDN:   nxt = (!sup_ok || timer == OE_LAST) ? PWR_OFF : PWR_SHUTDN;
            PWR_FAULT:    nxt = (fault_clr && sup_ok) ? PWR_OFF : PWR_FAULT;
            default:      nxt = PWR_OFF;
        endcase
    end

    // outputs are registered from the next state so gating happens on the same edge as the transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PWR_OFF;
            timer       <= '0;
            pad_bias_en <= 1'b0;
            pad_ie_en   <= 1'b0;
            pad_oe_en   <= 1'b0;
            io_ready    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= nxt;
            timer       <= (nxt != state) ? '0 : (timer == '1) ? timer : timer + 1'b1;
            pad_bias_en <= nxt inside {PWR_BIAS, PWR_INEN, PWR_READY, PWR_SHUTDN};
            pad_ie_en   <= nxt inside {PWR_INEN, PWR_READY, PWR_SHUTDN};
            pad_oe_en   <= nxt == PWR_READY;
            io_ready    <= nxt == PWR_READY;
            fault       <= nxt == PWR_FAULT;
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// tb_io_ring_pwr_seq: scoreboard bench; expected per-cycle state/outputs queued at stimulus time, compared after each edge.
module tb_io_ring_pwr_seq;
    import io_pwr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vddq_ok_async = 1'b0;
    logic vdd_ok_async = 1'b0;
    logic shutdown_req = 1'b0;
    logic fault_clr = 1'b0;
    logic pad_bias_en, pad_ie_en, pad_oe_en, io_ready, fault;
    logic [PWR_STATE_W-1:0] state_o;

    typedef struct {
        int cyc;
        pwr_state_e st;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    io_ring_pwr_seq dut (
        .clk(clk), .rst(rst),
        .vddq_ok_async(vddq_ok_async), .vdd_ok_async(vdd_ok_async),
        .shutdown_req(shutdown_req), .fault_clr(fault_clr),
        .pad_bias_en(pad_bias_en), .pad_ie_en(pad_ie_en), .pad_oe_en(pad_oe_en),
        .io_ready(io_ready), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // {state, fault, io_ready, oe, ie, bias}
    function automatic logic [7:0] exp_vec(input pwr_state_e s);
        logic bias, ie, rdy, f;
        bias = s inside {PWR_BIAS, PWR_INEN, PWR_READY, PWR_SHUTDN};
        ie = s inside {PWR_INEN, PWR_READY, PWR_SHUTDN};
        rdy = s == PWR_READY;
        f = s == PWR_FAULT;
        return {s, f, rdy, rdy, ie, bias};
    endfunction

    task automatic exp_rng(input int a, input int b, input pwr_state_e s);
        for (int i = a; i <= b; i++) sb.push_back('{i, s});
    endtask

    task automatic seq_up(input int d);
        exp_rng(d, d + 63, PWR_DEBOUNCE);
        exp_rng(d + 64, d + 79, PWR_BIAS);
        exp_rng(d + 80, d + 83, PWR_INEN);
    endtask

    task automatic wait_to(input int n);
        while (cyc != n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc == cyc)
                check($sformatf("c%0d", cyc),
                      {24'd0, state_o, fault, io_ready, pad_oe_en, pad_ie_en, pad_bias_en},
                      {24'd0, exp_vec(e.st)});
            else
                check($sformatf("late c%0d", e.cyc), cyc, e.cyc);
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: cycle %0d expected below 2000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        exp_rng(1, 12, PWR_OFF);
        wait_to(3);
        rst = 1'b0;
        wait_to(10);
        vddq_ok_async = 1'b1;
        vdd_ok_async = 1'b1;
        seq_up(13);
        exp_rng(97, 100, PWR_READY);
        wait_to(100);
        shutdown_req = 1'b1;
        exp_rng(101, 104, PWR_SHUTDN);
        exp_rng(105, 115, PWR_OFF);
        wait_to(115);
        shutdown_req = 1'b0;
        exp_rng(116, 158, PWR_DEBOUNCE);
        exp_rng(159, 159, PWR_OFF);
        wait_to(156);
        vddq_ok_async = 1'b0;
        wait_to(157);
        vddq_ok_async = 1'b1;
        seq_up(160);
        exp_rng(244, 252, PWR_READY);
        wait_to(250);
        vdd_ok_async = 1'b0;
        wait_to(252);
        shutdown_req = 1'b1;
        exp_rng(253, 265, PWR_FAULT);
        wait_to(256);
        fault_clr = 1'b1;
        wait_to(257);
        fault_clr = 1'b0;
        wait_to(260);
        shutdown_req = 1'b0;
        vdd_ok_async = 1'b1;
        wait_to(265);
        fault_clr = 1'b1;
        exp_rng(266, 266, PWR_OFF);
        wait_to(266);
        fault_clr = 1'b0;
        seq_up(267);
        exp_rng(351, 362, PWR_READY);
        wait_to(360);
        vdd_ok_async = 1'b0;
        exp_rng(363, 376, PWR_FAULT);
        wait_to(372);
        vdd_ok_async = 1'b1;
        wait_to(376);
        fault_clr = 1'b1;
        exp_rng(377, 377, PWR_OFF);
        wait_to(377);
        fault_clr = 1'b0;
        exp_rng(378, 441, PWR_DEBOUNCE);
        exp_rng(442, 457, PWR_BIAS);
        exp_rng(458, 459, PWR_INEN);
        wait_to(459);
        rst = 1'b1;
        exp_rng(460, 462, PWR_OFF);
        wait_to(460);
        rst = 1'b0;
        seq_up(463);
        exp_rng(547, 550, PWR_READY);
        wait_to(555);
        check("drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
